// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: MIPS execute stage with operand forwarding, ALU, iterative
// shift-add multiplier and branch-target adder feeding a valid/ready EX/MEM register.
module exe_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rt,
  input  logic [DATA_W-1:0] dato_1,
  input  logic [DATA_W-1:0] dato_2,
  input  logic              fwd_mem_rs,
  input  logic              fwd_mem_rt,
  input  logic              fwd_wb_rs,
  input  logic              fwd_wb_rt,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_result_hi,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_zero,
  output logic [PC_W-1:0]   out_br_target,
  output logic              busy
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_AND = 4'd1, OP_OR  = 4'd2, OP_NOR = 4'd3, OP_SUB = 4'd4,
    OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_MUL = 4'd8
  } alu_op_e;

  state_e              r_state, r_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_prod_hi;
  logic [DATA_W-1:0]   r_prod_lo;
  logic [REG_W-1:0]    r_mul_dest;
  logic [PC_W-1:0]     r_mul_br;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_result;
  logic [DATA_W-1:0]   r_out_result_hi;
  logic [REG_W-1:0]    r_out_dest;
  logic                r_out_zero;
  logic [PC_W-1:0]     r_out_br;

  alu_op_e             w_op;
  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;
  logic [DATA_W-1:0]   w_alu;
  logic                w_lt;
  logic [REG_W-1:0]    w_dest;
  logic [PC_W-1:0]     w_br_target;
  logic [DATA_W:0]     w_sum;
  logic                w_out_free;
  logic                w_accept;
  logic                w_is_mul;
  logic                w_load_alu;
  logic                w_load_mul;
  logic                w_mul_last;

  assign w_op        = alu_op_e'(alu_op);
  assign w_is_mul    = (w_op == OP_MUL);
  assign w_out_free  = ~r_out_valid | out_ready;
  assign in_ready    = (r_state == S_IDLE) & w_out_free;
  assign w_accept    = in_valid & in_ready;
  assign w_load_alu  = w_accept & ~w_is_mul;
  assign w_load_mul  = (r_state == S_DONE) & w_out_free;
  assign w_mul_last  = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_dest      = reg_dst ? rd : rt;
  assign w_br_target = pc + (PC_W'($signed(imm)) << 2);
  assign w_lt        = $signed(w_op_a) < $signed(w_op_b);

  always_comb begin
    w_op_a = dato_1;
    if (fwd_mem_rs)     w_op_a = mem_fwd;
    else if (fwd_wb_rs) w_op_a = wb_fwd;
    w_op_b = dato_2;
    if (alu_src)         w_op_b = imm;
    else if (fwd_mem_rt) w_op_b = mem_fwd;
    else if (fwd_wb_rt)  w_op_b = wb_fwd;
  end

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD:  w_alu = w_op_a + w_op_b;
      OP_AND:  w_alu = w_op_a & w_op_b;
      OP_OR:   w_alu = w_op_a | w_op_b;
      OP_NOR:  w_alu = ~(w_op_a | w_op_b);
      OP_SUB:  w_alu = w_op_a - w_op_b;
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, w_lt};
      OP_SLL:  w_alu = w_op_a << w_op_b[SH_W-1:0];
      OP_SRL:  w_alu = w_op_a >> w_op_b[SH_W-1:0];
      default: w_alu = '0;
    endcase
  end

  // Product lives in {hi,lo}; lo starts as the multiplier and is shifted out LSB-first.
  assign w_sum = {1'b0, r_prod_hi} + (r_prod_lo[0] ? {1'b0, r_mcand} : '0);

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) r_state_nxt = S_MUL;
      S_MUL:   if (w_mul_last)           r_state_nxt = S_DONE;
      S_DONE:  if (w_out_free)           r_state_nxt = S_IDLE;
      default: r_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_prod_hi  <= '0;
      r_prod_lo  <= '0;
      r_mul_dest <= '0;
      r_mul_br   <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt      <= '0;
      r_mcand    <= w_op_a;
      r_prod_hi  <= '0;
      r_prod_lo  <= w_op_b;
      r_mul_dest <= w_dest;
      r_mul_br   <= w_br_target;
    end else if (r_state == S_MUL) begin
      r_cnt      <= r_cnt + 1'b1;
      r_prod_hi  <= w_sum[DATA_W:1];
      r_prod_lo  <= {w_sum[0], r_prod_lo[DATA_W-1:1]};
    end
  end

  // Data fields only change on a load; a drain alone just drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_result    <= '0;
      r_out_result_hi <= '0;
      r_out_dest      <= '0;
      r_out_zero      <= 1'b0;
      r_out_br        <= '0;
    end else if (w_load_alu) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= w_alu;
      r_out_result_hi <= '0;
      r_out_dest      <= w_dest;
      r_out_zero      <= (w_alu == '0);
      r_out_br        <= w_br_target;
    end else if (w_load_mul) begin
      r_out_valid     <= 1'b1;
      r_out_result    <= r_prod_lo;
      r_out_result_hi <= r_prod_hi;
      r_out_dest      <= r_mul_dest;
      r_out_zero      <= (r_prod_lo == '0);
      r_out_br        <= r_mul_br;
    end else if (out_ready) begin
      r_out_valid     <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_result_hi = r_out_result_hi;
  assign out_dest      = r_out_dest;
  assign out_zero      = r_out_zero;
  assign out_br_target = r_out_br;
  assign busy          = (r_state == S_MUL);

endmodule
